// File: rtl/vmask_reduce.sv
// Two-stage mask reduction for vfirst.m / vcpop.m / vmsbf.m / vmsif.m / vmsof.m.
// S0 applies v0 and vl to the beat; S1 finds/counts, carries op state and drives outputs.
module vmask_reduce #(
    parameter int DATA_WIDTH      = 64,
    parameter int DATA_WIDTH_BITS = 6,
    parameter int IDX_BITS        = 10,
    parameter int ADDR_WIDTH      = 32,
    parameter int VL_BITS         = IDX_BITS + DATA_WIDTH_BITS + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_m0,
    input  logic [DATA_WIDTH-1:0] in_v0,
    input  logic [DATA_WIDTH-1:0] in_vd,
    input  logic                  in_vm,
    input  logic [VL_BITS-1:0]    in_vl,
    input  logic [IDX_BITS-1:0]   in_start_idx,
    input  logic                  in_end,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [2:0]            in_mode,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_valid,
    output logic                  out_scalar
);

    localparam logic [2:0] MODE_FIRST = 3'd0;
    localparam logic [2:0] MODE_CPOP  = 3'd1;
    localparam logic [2:0] MODE_MSBF  = 3'd2;
    localparam logic [2:0] MODE_MSIF  = 3'd3;
    localparam logic [2:0] MODE_MSOF  = 3'd4;

    function automatic logic [DATA_WIDTH_BITS:0] popcount(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH_BITS:0] c;
        c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            c = c + {{DATA_WIDTH_BITS{1'b0}}, v[i]};
        end
        return c;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lowest_one(input logic [DATA_WIDTH-1:0] v);
        return v & (~v + DATA_WIDTH'(1));
    endfunction

    function automatic logic [DATA_WIDTH_BITS-1:0] lowest_pos(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH_BITS-1:0] p;
        p = '0;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (v[i]) p = DATA_WIDTH_BITS'(i);
        end
        return p;
    endfunction

    // ---------------- S0: activity and effective mask ----------------
    logic [VL_BITS-1:0]    base_in;
    logic [DATA_WIDTH-1:0] act_in;

    always_comb begin
        base_in = VL_BITS'({in_start_idx, {DATA_WIDTH_BITS{1'b0}}});
        act_in  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            act_in[i] = (in_vm | in_v0[i]) & ((base_in + VL_BITS'(i)) < in_vl);
        end
    end

    logic                  vld_p0;
    logic                  end_p0;
    logic [2:0]            mode_p0;
    logic [VL_BITS-1:0]    base_p0;
    logic [DATA_WIDTH-1:0] act_p0;
    logic [DATA_WIDTH-1:0] eff_p0;
    logic [DATA_WIDTH-1:0] vd_p0;
    logic [ADDR_WIDTH-1:0] addr_p0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) vld_p0 <= 1'b0;
        else      vld_p0 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid) begin
            end_p0  <= in_end;
            mode_p0 <= in_mode;
            base_p0 <= base_in;
            act_p0  <= act_in;
            eff_p0  <= in_m0 & act_in;
            vd_p0   <= in_vd;
            addr_p0 <= in_addr;
        end
    end

    // ---------------- S1: find, count, carried state, outputs ----------------
    logic [DATA_WIDTH-1:0]      f_p0;
    logic [DATA_WIDTH_BITS:0]   pc_p0;
    logic                       hit_p0;
    logic [VL_BITS-1:0]         hit_idx_p0;

    logic                  found_p1, found_nxt;
    logic [VL_BITS-1:0]    first_idx_p1, first_idx_nxt;
    logic [DATA_WIDTH-1:0] count_p1, count_nxt;

    always_comb begin
        f_p0       = lowest_one(eff_p0);
        pc_p0      = popcount(eff_p0);
        hit_p0     = |eff_p0;
        hit_idx_p0 = base_p0 + VL_BITS'(lowest_pos(eff_p0));
    end

    always_comb begin
        found_nxt     = found_p1;
        first_idx_nxt = first_idx_p1;
        count_nxt     = count_p1;
        if (vld_p0) begin
            if (end_p0) begin
                found_nxt     = 1'b0;
                first_idx_nxt = '0;
                count_nxt     = '0;
            end else begin
                found_nxt = found_p1 | hit_p0;
                if (!found_p1 && hit_p0) first_idx_nxt = hit_idx_p0;
                count_nxt = count_p1 + DATA_WIDTH'(pc_p0);
            end
        end
    end

    logic                  vld_nxt;
    logic                  scalar_nxt;
    logic [DATA_WIDTH-1:0] vec_nxt;
    logic [DATA_WIDTH-1:0] r_p0;

    always_comb begin
        vld_nxt    = 1'b0;
        scalar_nxt = 1'b0;
        vec_nxt    = '0;
        r_p0       = '0;
        if (vld_p0) begin
            case (mode_p0)
                MODE_FIRST: if (end_p0) begin
                    vld_nxt    = 1'b1;
                    scalar_nxt = 1'b1;
                    if (found_p1)    vec_nxt = DATA_WIDTH'(first_idx_p1);
                    else if (hit_p0) vec_nxt = DATA_WIDTH'(hit_idx_p0);
                    else             vec_nxt = '1;
                end
                MODE_CPOP: if (end_p0) begin
                    vld_nxt    = 1'b1;
                    scalar_nxt = 1'b1;
                    vec_nxt    = count_p1 + DATA_WIDTH'(pc_p0);
                end
                MODE_MSBF, MODE_MSIF, MODE_MSOF: begin
                    vld_nxt = 1'b1;
                    if (found_p1)                 r_p0 = '0;
                    else if (mode_p0 == MODE_MSOF) r_p0 = f_p0;
                    else if (!hit_p0)              r_p0 = '1;
                    else if (mode_p0 == MODE_MSBF) r_p0 = f_p0 - DATA_WIDTH'(1);
                    else                           r_p0 = (f_p0 - DATA_WIDTH'(1)) | f_p0;
                    // inactive (masked-off or tail) positions keep the old destination
                    vec_nxt = (r_p0 & act_p0) | (vd_p0 & ~act_p0);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            found_p1     <= 1'b0;
            first_idx_p1 <= '0;
            count_p1     <= '0;
            out_valid    <= 1'b0;
            out_scalar   <= 1'b0;
            out_vec      <= '0;
            out_addr     <= '0;
        end else begin
            found_p1     <= found_nxt;
            first_idx_p1 <= first_idx_nxt;
            count_p1     <= count_nxt;
            out_valid    <= vld_nxt;
            out_scalar   <= scalar_nxt;
            out_vec      <= vec_nxt;
            out_addr     <= vld_nxt ? addr_p0 : '0;
        end
    end

endmodule

// File: tb/tb_vmask_reduce.sv
// Bench for vmask_reduce: directed single-beat table, multi-beat sequences,
// and random ops checked against an op-level model over global bit indices.
module tb_vmask_reduce;

    localparam int DW  = 64;
    localparam int DWB = 6;
    localparam int IB  = 10;
    localparam int AW  = 32;
    localparam int VLB = IB + DWB + 1;
    localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic [DW-1:0]  in_m0, in_v0, in_vd;
    logic           in_vm;
    logic [VLB-1:0] in_vl;
    logic [IB-1:0]  in_start_idx;
    logic           in_end;
    logic [AW-1:0]  in_addr;
    logic [2:0]     in_mode;
    logic [DW-1:0]  out_vec;
    logic [AW-1:0]  out_addr;
    logic           out_valid;
    logic           out_scalar;

    always #5 clk = ~clk;

    vmask_reduce #(
        .DATA_WIDTH(DW), .DATA_WIDTH_BITS(DWB), .IDX_BITS(IB), .ADDR_WIDTH(AW), .VL_BITS(VLB)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_m0(in_m0), .in_v0(in_v0),
        .in_vd(in_vd), .in_vm(in_vm), .in_vl(in_vl), .in_start_idx(in_start_idx),
        .in_end(in_end), .in_addr(in_addr), .in_mode(in_mode), .out_vec(out_vec),
        .out_addr(out_addr), .out_valid(out_valid), .out_scalar(out_scalar)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic beat(input logic [2:0] mode, input logic vm, input logic [VLB-1:0] vl,
                        input logic [IB-1:0] idx, input logic [63:0] m0, input logic [63:0] v0,
                        input logic [63:0] vd, input logic e, input logic [AW-1:0] addr);
        in_valid = 1'b1; in_mode = mode; in_vm = vm; in_vl = vl; in_start_idx = idx;
        in_m0 = m0; in_v0 = v0; in_vd = vd; in_end = e; in_addr = addr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_end   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    typedef struct packed {
        logic [2:0]     mode;
        logic           vm;
        logic [VLB-1:0] vl;
        logic [IB-1:0]  idx;
        logic [63:0]    m0;
        logic [63:0]    v0;
        logic [63:0]    vd;
        logic           exp_valid;
        logic [63:0]    exp_vec;
        logic           exp_scalar;
    } vec_t;

    typedef struct packed {
        logic [63:0]   vec;
        logic [AW-1:0] addr;
        logic          scalar;
    } res_t;

    vec_t tbl[16];
    res_t exp_q[$];
    res_t obs_q[$];
    logic mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && out_valid) obs_q.push_back('{out_vec, out_addr, out_scalar});
    end

    logic [63:0] rm0[4], rv0[4], rvd[4];

    initial begin
        tbl[0]  = '{3'd1, 1'b0, 17'd64,  10'd0, 64'h0F0F, 64'h00FF, 64'h0, 1'b1, 64'd4, 1'b1};
        tbl[1]  = '{3'd2, 1'b1, 17'd64,  10'd0, 64'h10, 64'h0, 64'h0, 1'b1, 64'h0F, 1'b0};
        tbl[2]  = '{3'd3, 1'b1, 17'd64,  10'd0, 64'h10, 64'h0, 64'h0, 1'b1, 64'h1F, 1'b0};
        tbl[3]  = '{3'd4, 1'b1, 17'd64,  10'd0, 64'h10, 64'h0, 64'h0, 1'b1, 64'h10, 1'b0};
        tbl[4]  = '{3'd4, 1'b0, 17'd64,  10'd0, 64'h22, 64'hF0, 64'h0F, 1'b1, 64'h2F, 1'b0};
        tbl[5]  = '{3'd0, 1'b1, 17'd0,   10'd0, ALL, ALL, 64'h0, 1'b1, ALL, 1'b1};
        tbl[6]  = '{3'd1, 1'b1, 17'd0,   10'd0, ALL, ALL, 64'h0, 1'b1, 64'd0, 1'b1};
        tbl[7]  = '{3'd2, 1'b1, 17'd0,   10'd0, ALL, ALL, 64'h0123456789ABCDEF, 1'b1,
                    64'h0123456789ABCDEF, 1'b0};
        tbl[8]  = '{3'd0, 1'b1, 17'd64,  10'd0, 64'h8, 64'h0, 64'h0, 1'b1, 64'd3, 1'b1};
        tbl[9]  = '{3'd1, 1'b1, 17'd10,  10'd0, ALL, 64'h0, 64'h0, 1'b1, 64'd10, 1'b1};
        tbl[10] = '{3'd2, 1'b1, 17'd64,  10'd0, 64'h0, 64'h0, 64'h55, 1'b1, ALL, 1'b0};
        tbl[11] = '{3'd3, 1'b1, 17'd8,   10'd0, 64'h0, 64'h0, 64'hFF00, 1'b1, 64'hFFFF, 1'b0};
        tbl[12] = '{3'd0, 1'b1, 17'd256, 10'd3, 64'h20, 64'h0, 64'h0, 1'b1, 64'd197, 1'b1};
        tbl[13] = '{3'd1, 1'b1, 17'd64,  10'd0, ALL, 64'h0, 64'h0, 1'b1, 64'd64, 1'b1};
        tbl[14] = '{3'd5, 1'b1, 17'd64,  10'd0, ALL, 64'h0, 64'h0, 1'b0, 64'd0, 1'b0};
        tbl[15] = '{3'd0, 1'b0, 17'd64,  10'd0, 64'h0F, 64'hF0, 64'h0, 1'b1, ALL, 1'b1};

        rst = 1'b0;
        in_valid = 0; in_m0 = 0; in_v0 = 0; in_vd = 0; in_vm = 0; in_vl = 0;
        in_start_idx = 0; in_end = 0; in_addr = 0; in_mode = 0;
        repeat (3) @(negedge clk);
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        check("reset_vec", out_vec, 64'd0);
        check("reset_addr", {32'd0, out_addr}, 64'd0);
        rst = 1'b1;
        idle(2);

        // single-beat ops with exact two-cycle latency and a one-cycle pulse
        for (int k = 0; k < 16; k++) begin
            beat(tbl[k].mode, tbl[k].vm, tbl[k].vl, tbl[k].idx, tbl[k].m0, tbl[k].v0, tbl[k].vd,
                 1'b1, 32'h1000 + k);
            in_valid = 1'b0;
            check($sformatf("tbl%0d_early", k), {63'd0, out_valid}, 64'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_valid", k), {63'd0, out_valid}, {63'd0, tbl[k].exp_valid});
            check($sformatf("tbl%0d_vec", k), out_vec, tbl[k].exp_vec);
            check($sformatf("tbl%0d_scalar", k), {63'd0, out_scalar}, {63'd0, tbl[k].exp_scalar});
            check($sformatf("tbl%0d_addr", k), {32'd0, out_addr},
                  tbl[k].exp_valid ? 64'h1000 + k : 64'd0);
            @(negedge clk);
            check($sformatf("tbl%0d_pulse", k), {63'd0, out_valid}, 64'd0);
        end

        // vfirst across two beats
        beat(3'd0, 1'b1, 17'd128, 10'd0, 64'h0, 64'h0, 64'h0, 1'b0, 32'hA0);
        beat(3'd0, 1'b1, 17'd128, 10'd1, 64'h100, 64'h0, 64'h0, 1'b1, 32'hA1);
        in_valid = 1'b0;
        check("first2_nobeatout", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("first2_valid", {63'd0, out_valid}, 64'd1);
        check("first2_vec", out_vec, 64'd72);
        check("first2_scalar", {63'd0, out_scalar}, 64'd1);
        check("first2_addr", {32'd0, out_addr}, 64'hA1);
        idle(2);

        // vfirst: the only set bit lies in the tail
        beat(3'd0, 1'b1, 17'd70, 10'd0, 64'h0, 64'h0, 64'h0, 1'b0, 32'hB0);
        beat(3'd0, 1'b1, 17'd70, 10'd1, 64'h400, 64'h0, 64'h0, 1'b1, 32'hB1);
        in_valid = 1'b0;
        @(negedge clk);
        check("tail_vfirst", out_vec, ALL);
        idle(2);

        // set-before/including/only-first: second beat after the find is zero
        for (int m = 2; m <= 4; m++) begin
            logic [63:0] first_exp;
            first_exp = (m == 2) ? 64'h0F : (m == 3) ? 64'h1F : 64'h10;
            beat(3'(m), 1'b1, 17'd128, 10'd0, 64'h10, 64'h0, 64'h0, 1'b0, 32'hC0);
            beat(3'(m), 1'b1, 17'd128, 10'd1, 64'h10, 64'h0, 64'h0, 1'b1, 32'hC1);
            in_valid = 1'b0;
            check($sformatf("mask%0d_b0_vec", m), out_vec, first_exp);
            check($sformatf("mask%0d_b0_addr", m), {32'd0, out_addr}, 64'hC0);
            @(negedge clk);
            check($sformatf("mask%0d_b1_valid", m), {63'd0, out_valid}, 64'd1);
            check($sformatf("mask%0d_b1_vec", m), out_vec, 64'd0);
            idle(2);
        end

        // back-to-back ops with no bubble
        beat(3'd1, 1'b1, 17'd64, 10'd0, 64'hFF, 64'h0, 64'h0, 1'b1, 32'hD0);
        beat(3'd0, 1'b1, 17'd64, 10'd0, 64'h8, 64'h0, 64'h0, 1'b1, 32'hD1);
        in_valid = 1'b0;
        check("b2b_cpop", out_vec, 64'd8);
        check("b2b_cpop_addr", {32'd0, out_addr}, 64'hD0);
        @(negedge clk);
        check("b2b_first", out_vec, 64'd3);
        check("b2b_first_addr", {32'd0, out_addr}, 64'hD1);
        idle(2);

        // reset in the middle of an op that has already found a bit
        beat(3'd0, 1'b1, 17'd128, 10'd0, 64'h4, 64'h0, 64'h0, 1'b0, 32'hE0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_valid0", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        check("rst_mid_valid1", {63'd0, out_valid}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        check("rst_after_valid", {63'd0, out_valid}, 64'd0);
        beat(3'd0, 1'b1, 17'd64, 10'd0, 64'h8, 64'h0, 64'h0, 1'b1, 32'hE1);
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_new_valid", {63'd0, out_valid}, 64'd1);
        check("rst_new_vec", out_vec, 64'd3);
        idle(2);

        // random ops against an op-level model
        mon_en = 1'b1;
        for (int op = 0; op < 200; op++) begin
            int nb, first, cnt, nbits;
            logic [2:0] mode;
            logic vm;
            logic [VLB-1:0] vl;
            nb    = $urandom_range(1, 4);
            mode  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            vm    = 1'($urandom_range(0, 1));
            vl    = VLB'($urandom_range(0, nb * 64 + 16));
            nbits = nb * 64;
            for (int b = 0; b < nb; b++) begin
                int kind;
                kind   = $urandom_range(0, 2);
                rm0[b] = (kind == 0) ? 64'h0 :
                         (kind == 1) ? (64'h1 << $urandom_range(0, 63)) :
                         ({$urandom, $urandom} & {$urandom, $urandom});
                rv0[b] = {$urandom, $urandom};
                rvd[b] = {$urandom, $urandom};
            end
            first = -1;
            cnt   = 0;
            for (int j = 0; j < nbits; j++) begin
                if ((vm || rv0[j / 64][j % 64]) && j < int'(vl) && rm0[j / 64][j % 64]) begin
                    cnt++;
                    if (first < 0) first = j;
                end
            end
            if (mode == 3'd0)
                exp_q.push_back('{(first < 0) ? ALL : 64'(first), AW'(op * 16 + nb - 1), 1'b1});
            else if (mode == 3'd1)
                exp_q.push_back('{64'(cnt), AW'(op * 16 + nb - 1), 1'b1});
            else if (mode <= 3'd4) begin
                for (int b = 0; b < nb; b++) begin
                    logic [63:0] v;
                    for (int i = 0; i < 64; i++) begin
                        int j;
                        j = b * 64 + i;
                        if ((vm || rv0[b][i]) && j < int'(vl))
                            v[i] = (mode == 3'd2) ? (first < 0 || j < first) :
                                   (mode == 3'd3) ? (first < 0 || j <= first) : (j == first);
                        else
                            v[i] = rvd[b][i];
                    end
                    exp_q.push_back('{v, AW'(op * 16 + b), 1'b0});
                end
            end
            for (int b = 0; b < nb; b++) begin
                beat(mode, vm, vl, IB'(b), rm0[b], rv0[b], rvd[b], b == nb - 1, AW'(op * 16 + b));
                if (b != nb - 1 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(5);
        mon_en = 1'b0;

        foreach (exp_q[k]) begin
            if (obs_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL rand_missing: got no output, expected result %0d of %0d", k, exp_q.size());
                break;
            end else begin
                res_t o;
                o = obs_q.pop_front();
                check($sformatf("rand%0d_vec", k), o.vec, exp_q[k].vec);
                check($sformatf("rand%0d_addr", k), {32'd0, o.addr}, {32'd0, exp_q[k].addr});
                check($sformatf("rand%0d_scalar", k), {63'd0, o.scalar}, {63'd0, exp_q[k].scalar});
            end
        end
        check("rand_extra_outputs", 64'(obs_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vmask_reduce.md
Name: vmask_reduce

Overview:
- Pipelined mask-reduction unit in the vALU for mask-producing and mask-reducing ops: vfirst.m, vcpop.m, vmsbf.m, vmsif.m, vmsof.m.
- Consumes a mask vector as ordered beats of DATA_WIDTH bits. Carries first-found and popcount state across beats.
- Scalar ops produce one result after the end beat. Set-before/including/only-first ops produce one output beat per input beat.
- Adds v0 masking, vl tail handling and mask-undisturbed merge.

Parameters:
DATA_WIDTH, 64, mask bits per beat; also width of out_vec.
DATA_WIDTH_BITS, 6, log2(DATA_WIDTH).
IDX_BITS, 10, beat-index width.
ADDR_WIDTH, 32, destination address/tag width.
VL_BITS, IDX_BITS+DATA_WIDTH_BITS+1, in_vl width.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  reset, asynchronous, active-low (asserted when 0).
in_valid  in  1  beat valid; no backpressure.
in_m0  in  DATA_WIDTH  source mask beat (vs2).
in_v0  in  DATA_WIDTH  v0 mask beat.
in_vd  in  DATA_WIDTH  old destination beat, used for merge.
in_vm  in  1  1 = unmasked op.
in_vl  in  VL_BITS  vector length.
in_start_idx  in  IDX_BITS  beat index.
in_end  in  1  last beat of the op.
in_addr  in  ADDR_WIDTH  destination tag.
in_mode  in  3  0 vfirst, 1 vcpop, 2 vmsbf, 3 vmsif, 4 vmsof, 5-7 reserved.
out_vec  out  DATA_WIDTH  scalar result or mask beat.
out_addr  out  ADDR_WIDTH  tag of the producing beat.
out_valid  out  1  out_vec valid.
out_scalar  out  1  1 = out_vec holds a scalar result.

Behaviour:
Reset:
- rst=0 clears asynchronously: all outputs, pipeline valids and carried state (found, first_idx, count).
- Reset mid-op discards the op; no output is produced for it.

Pipeline:
- S0 registers the beat and computes base = in_start_idx<<DATA_WIDTH_BITS.
- S0 computes act[i] = (in_vm | in_v0[i]) & (base+i < in_vl) and eff = in_m0 & act.
- S1 computes f = lowest set bit of eff (one-hot), the bit position, and popcount(eff). S1 updates the carried state and registers the outputs.
- Latency: 2 cycles from an input beat to its output beat or scalar result.
- Throughput: 1 beat/cycle. in_valid gaps are allowed.
- Beats arrive in ascending, contiguous index order. in_mode, in_vm and in_vl are constant within an op.

Scalar modes (0, 1):
- No per-beat outputs.
- On the end beat, out_valid=1, out_scalar=1, out_addr = end-beat addr.
- vfirst: out_vec = global index of the first eff bit (found state or this beat); all-ones if none found.
- vcpop: out_vec = count + popcount(eff), zero-extended.

Mask modes (2-4), every beat:
- out_valid=1, out_scalar=0.
- Let g = the carried found flag.
- vmsbf: r = g ? 0 : (f ? f-1 : all-ones).
- vmsif: r = g ? 0 : (f ? (f-1)|f : all-ones).
- vmsof: r = g ? 0 : f.
- out_vec = (r & act) | (in_vd & ~act). Masked-off and tail bits are undisturbed.

Carried state:
- Applies to all modes: found |= (eff != 0); first_idx latched at the first find; count += popcount.
- If S1 processes the end beat, the next state is zero, not updated. A new op may start on the cycle after in_end with no bubble.

Reserved modes:
- Beats are consumed and produce no output. The end beat clears the state.

Boundaries:
- vl=0: all bits inactive. vfirst returns -1, vcpop returns 0, mask modes return in_vd.
- Bits with index >= vl never count and are never found.
- The count does not wrap: its width is DATA_WIDTH ≥ VL_BITS.
- out_valid is a 1-cycle pulse per output. Outputs are 0 when out_valid=0.

Test Plan:
- vfirst, vm=1, vl=128: beat0 m0=0, beat1 m0=0x100 end -> 2 cycles after end: out_vec=72, out_scalar=1, out_addr=end tag.
- vcpop, vm=0, v0=0x00FF, m0=0x0F0F, vl=64, single end beat -> out_vec=4.
- vl=64, m0=0x10, vm=1, vd=0, one beat each -> vmsbf 0x0F, vmsif 0x1F, vmsof 0x10. A second beat after the find -> 0.
- Tail/merge:
  - vfirst, vl=70, beat1 m0 bit10 only -> all-ones.
  - vmsof, vm=0, v0=0xF0, vd=0x0F, m0=0x22 -> 0x2F.
- Back-to-back: vcpop end beat (m0=0xFF) then vfirst beat next cycle (m0=0x8, end) -> 8, then 3 on consecutive cycles. No state leakage.
- Reset: assert rst after a found beat, release, run vfirst m0=0x8 -> 3. out_valid stays 0 during reset and for the aborted op.
